// File: rtl/zero_loop_if.sv
// Interface between the loop sequencer and its surroundings.
// It carries the start/done exchange with the control unit and the step
// valid/ready handshake with the ALU step logic.
//   master : the loop sequencer (zero_loop_ctrl)
//   slave  : the control unit and datapath side (testbench or integrator)
// Signals: start, count_in, step_ready, step_valid, count_out, zero_flag,
//          busy, done; plus abort/aborted when LOOP_ABORT_EN is defined.
interface zero_loop_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] count_in;
  logic             step_valid;
  logic             step_ready;
  logic [WIDTH-1:0] count_out;
  logic             zero_flag;
  logic             busy;
  logic             done;
`ifdef LOOP_ABORT_EN
  logic             abort;
  logic             aborted;
`endif

  modport master (
    input  start, count_in, step_ready,
`ifdef LOOP_ABORT_EN
    input  abort,
    output aborted,
`endif
    output step_valid, count_out, zero_flag, busy, done
  );

  modport slave (
    output start, count_in, step_ready,
`ifdef LOOP_ABORT_EN
    output abort,
    input  aborted,
`endif
    input  step_valid, count_out, zero_flag, busy, done
  );
endinterface

// File: rtl/zero_loop_ctrl.sv
// zero_loop_ctrl: loop sequencer for the 8-bit zero-detect datapath.
// It loads an iteration count on start and issues one step request per
// iteration over a valid/ready handshake. It decrements the counter on each
// accepted step and finishes when the counter reaches zero.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    zero_loop_if.master (start, count_in, step_ready in;
//          step_valid, count_out, zero_flag, busy, done out;
//          abort in / aborted out when LOOP_ABORT_EN is defined)
// Parameters:
//   WIDTH        counter and count_in width
//   AUTO_RELOAD  1: a start seen in DONE reloads and goes straight back to RUN
// Optional feature macro: LOOP_ABORT_EN. When it is defined, an abort input
// ends a running loop early and sets the sticky aborted flag.
module zero_loop_ctrl #(
  parameter int WIDTH       = 8,
  parameter bit AUTO_RELOAD = 1'b0
) (
  input  logic         clk,
  input  logic         rst_n,
  zero_loop_if.master  bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] counter;
  logic             load;
  logic             dec;
  logic             step_valid;
  logic             busy;
  logic             done;
`ifdef LOOP_ABORT_EN
  logic             set_abort;
  logic             aborted;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    load       = 1'b0;
    dec        = 1'b0;
    step_valid = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
`ifdef LOOP_ABORT_EN
    set_abort  = 1'b0;
`endif
    case (state)
      S_IDLE: begin
        if (bus.start) begin
          load      = 1'b1;
          // A zero count skips RUN entirely, so no step is ever issued.
          state_nxt = (bus.count_in == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        step_valid = 1'b1;
        busy       = 1'b1;
`ifdef LOOP_ABORT_EN
        // Abort takes priority over a handshake in the same cycle.
        if (bus.abort) begin
          set_abort = 1'b1;
          state_nxt = S_DONE;
        end else if (bus.step_ready) begin
          dec = 1'b1;
          if (counter == WIDTH'(1)) state_nxt = S_DONE;
        end
`else
        if (bus.step_ready) begin
          dec = 1'b1;
          if (counter == WIDTH'(1)) state_nxt = S_DONE;
        end
`endif
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
        if (AUTO_RELOAD && bus.start) begin
          load      = 1'b1;
          state_nxt = (bus.count_in == '0) ? S_DONE : S_RUN;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // The decrement is only enabled in RUN, and RUN is only ever entered or
  // held with counter >= 1, so the counter cannot wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      counter <= '0;
    end else if (load) begin
      counter <= bus.count_in;
    end else if (dec) begin
      counter <= counter - WIDTH'(1);
    end
  end

`ifdef LOOP_ABORT_EN
  // Sticky flag: it records how the previous loop ended and stays set until
  // the next accepted start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aborted <= 1'b0;
    end else if (load) begin
      aborted <= 1'b0;
    end else if (set_abort) begin
      aborted <= 1'b1;
    end
  end

  assign bus.aborted = aborted;
`endif

  assign bus.step_valid = step_valid;
  assign bus.busy       = busy;
  assign bus.done       = done;
  assign bus.count_out  = counter;
  assign bus.zero_flag  = ~|counter;

endmodule
